mem_port_arbiter: RTL and testbench

- Shares one single-port, synchronous-read 32-bit memory between the core's instruction-fetch port and its data port.
- Sits between `Riscv_Top` (imaddr/instr, dmaddr/dmdata/dmwr_mask/dmwr_req) and a unified memory array.
- Picks one requester per cycle, drives the memory port, and returns read data one cycle later, tagged to the requester that issued the read.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous-read memory between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise fixed DM priority + starve guard.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_gnt_out,
  output logic              if_rvalid_out,
  output logic [31:0]       if_rdata_out,
  input  logic              dm_req_in,
  input  logic              dm_we_in,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic [31:0]       dm_wdata_in,
  input  logic [3:0]        dm_mask_in,
  output logic              dm_gnt_out,
  output logic              dm_rvalid_out,
  output logic [31:0]       dm_rdata_out,
  output logic              mem_en_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_wdata_out,
  output logic [3:0]        mem_mask_out,
  input  logic [31:0]       mem_rdata_in
);

  typedef enum logic [1:0] {TagNone, TagIf, TagDm} tag_e;

  tag_e rd_tag_q, rd_tag_d;
  logic if_wins_contest;
  logic contested;

  assign contested = if_req_in & dm_req_in;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {LastIf, LastDm} last_e;
  last_e last_q;

  assign if_wins_contest = (last_q == LastDm);

  // Only contested cycles move the last-winner pointer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_q <= LastDm;
    end else if (contested) begin
      last_q <= if_gnt_out ? LastIf : LastDm;
    end
  end
`else
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [StarveW-1:0] starve_q;

  assign if_wins_contest = (starve_q == StarveW'(STARVE_MAX));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_q <= '0;
    end else if (if_gnt_out) begin
      starve_q <= '0;
    end else if (contested) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`endif

  always_comb begin
    if_gnt_out = if_req_in & (~dm_req_in | if_wins_contest);
    dm_gnt_out = dm_req_in & ~if_gnt_out;
  end

  assign mem_en_out = if_gnt_out | dm_gnt_out;

  always_comb begin
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    mem_mask_out  = '0;
    if (if_gnt_out) begin
      mem_addr_out = if_addr_in;
    end else if (dm_gnt_out) begin
      mem_we_out    = dm_we_in;
      mem_addr_out  = dm_addr_in;
      mem_wdata_out = dm_wdata_in;
      mem_mask_out  = dm_mask_in;
    end
  end

  always_comb begin
    rd_tag_d = TagNone;
    if (if_gnt_out) begin
      rd_tag_d = TagIf;
    end else if (dm_gnt_out && !dm_we_in) begin
      rd_tag_d = TagDm;
    end
  end

  // Reset discards any read still in flight, so its return is never tagged.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_tag_q <= TagNone;
    end else begin
      rd_tag_q <= rd_tag_d;
    end
  end

  always_comb begin
    if_rvalid_out = (rd_tag_q == TagIf);
    dm_rvalid_out = (rd_tag_q == TagDm);
    if_rdata_out  = if_rvalid_out ? mem_rdata_in : 32'h0;
    dm_rdata_out  = dm_rvalid_out ? mem_rdata_in : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
// Honours ARB_ROUND_ROBIN_EN to select the expected contention pattern.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 6;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int Contest = 13;
`else
  localparam int Contest = 14;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata, dm_rdata;
  logic [3:0]        dm_mask;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_mask;
  logic [31:0]       mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .if_req_in    (if_req),
    .if_addr_in   (if_addr),
    .if_gnt_out   (if_gnt),
    .if_rvalid_out(if_rvalid),
    .if_rdata_out (if_rdata),
    .dm_req_in    (dm_req),
    .dm_we_in     (dm_we),
    .dm_addr_in   (dm_addr),
    .dm_wdata_in  (dm_wdata),
    .dm_mask_in   (dm_mask),
    .dm_gnt_out   (dm_gnt),
    .dm_rvalid_out(dm_rvalid),
    .dm_rdata_out (dm_rdata),
    .mem_en_out   (mem_en),
    .mem_we_out   (mem_we),
    .mem_addr_out (mem_addr),
    .mem_wdata_out(mem_wdata),
    .mem_mask_out (mem_mask),
    .mem_rdata_in (mem_rdata)
  );

  // Memory contents are reloaded whenever reset is high; read data register is not reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[3]  <= 32'hDEADBEEF;
      mem[10] <= 32'h1111000A;
      mem[20] <= 32'h22220014;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_if;
    logic prev_if;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_mask = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_gnts", {30'd0, if_gnt, dm_gnt}, 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    edge_in();
    rst = 1'b0;

    // Single IF read of addr 3
    edge_in();
    if_req = 1'b1; if_addr = 6'd3;
    @(negedge clk);
    check("t1_if_gnt", 32'(if_gnt), 32'd1);
    check("t1_dm_gnt", 32'(dm_gnt), 32'd0);
    check("t1_mem_en", 32'(mem_en), 32'd1);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    check("t1_mem_addr", 32'(mem_addr), 32'd3);
    check("t1_mem_mask", 32'(mem_mask), 32'd0);
    edge_in();
    if_req = 1'b0;
    @(negedge clk);
    check("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("t1_dm_rdata", dm_rdata, 32'h0);
    check("t1_idle_mem_en", 32'(mem_en), 32'd0);

    // DM masked write then read back
    edge_in();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd5; dm_wdata = 32'h12345678; dm_mask = 4'b0011;
    @(negedge clk);
    check("t2_wr_gnt", 32'(dm_gnt), 32'd1);
    check("t2_wr_we", 32'(mem_we), 32'd1);
    check("t2_wr_mask", 32'(mem_mask), 32'h3);
    check("t2_wr_wdata", mem_wdata, 32'h12345678);
    check("t2_wr_addr", 32'(mem_addr), 32'd5);
    check("t2_wr_if_rvalid", 32'(if_rvalid), 32'd0);
    edge_in();
    dm_we = 1'b0; dm_wdata = '0; dm_mask = '0;
    @(negedge clk);
    check("t2_rd_gnt", 32'(dm_gnt), 32'd1);
    check("t2_rd_we", 32'(mem_we), 32'd0);
    check("t2_wr_no_rvalid", 32'(dm_rvalid), 32'd0);
    edge_in();
    dm_req = 1'b0;
    @(negedge clk);
    check("t2_rd_rvalid", 32'(dm_rvalid), 32'd1);
    check("t2_rd_rdata", dm_rdata, 32'h00005678);
    check("t2_rd_if_rvalid", 32'(if_rvalid), 32'd0);

    // Continuous contention: IF reads addr 10, DM reads addr 20
    edge_in();
    if_req = 1'b1; if_addr = 6'd10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd20;
    prev_if = 1'b0;
    for (int i = 0; i < Contest; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_if = (i % 2 == 0);
`else
      exp_if = (i % 5 == 4);
`endif
      @(negedge clk);
      check($sformatf("t3_if_gnt_%0d", i), 32'(if_gnt), 32'(exp_if));
      check($sformatf("t3_dm_gnt_%0d", i), 32'(dm_gnt), 32'(!exp_if));
      check($sformatf("t3_addr_%0d", i), 32'(mem_addr), exp_if ? 32'd10 : 32'd20);
      if (i > 0) begin
        check($sformatf("t3_if_rv_%0d", i), 32'(if_rvalid), 32'(prev_if));
        check($sformatf("t3_dm_rv_%0d", i), 32'(dm_rvalid), 32'(!prev_if));
        check($sformatf("t3_rdata_%0d", i), prev_if ? if_rdata : dm_rdata,
              prev_if ? 32'h1111000A : 32'h22220014);
      end
      prev_if = exp_if;
      edge_in();
    end

    // Reset with a read outstanding, then contested cycle checks arbitration state reset
    if_req = 1'b0; dm_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t4_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("t4_rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("t4_rst_dm_rdata", dm_rdata, 32'h0);
    edge_in();
    rst = 1'b0; if_req = 1'b1; if_addr = 6'd3; dm_req = 1'b1; dm_addr = 6'd20;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp_if = 1'b1;
`else
    exp_if = 1'b0;
`endif
    check("t4_post_rst_if_gnt", 32'(if_gnt), 32'(exp_if));
    check("t4_post_rst_dm_gnt", 32'(dm_gnt), 32'(!exp_if));
    edge_in();
    if_req = !exp_if; dm_req = exp_if;
    @(negedge clk);
    check("t4_loser_gnt", {30'd0, if_gnt, dm_gnt}, exp_if ? 32'd1 : 32'd2);
    edge_in();
    if_req = 1'b0; dm_req = 1'b0;

    // IF read granted, reset pulsed on the return cycle
    edge_in();
    if_req = 1'b1; if_addr = 6'd3;
    @(negedge clk);
    check("t5_if_gnt", 32'(if_gnt), 32'd1);
    edge_in();
    if_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t5_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("t5_rst_if_rdata", if_rdata, 32'h0);
    edge_in();
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_if_rvalid", 32'(if_rvalid), 32'd0);
    edge_in();
    if_req = 1'b1; if_addr = 6'd3;
    @(negedge clk);
    check("t5_regrant", 32'(if_gnt), 32'd1);
    edge_in();
    if_req = 1'b0;
    @(negedge clk);
    check("t5_re_rvalid", 32'(if_rvalid), 32'd1);
    check("t5_re_rdata", if_rdata, 32'hDEADBEEF);

    // Same-cycle DM write and IF read to addr 7
    edge_in();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd7; dm_wdata = 32'hA5A5A5A5; dm_mask = 4'hF;
    if_req = 1'b1; if_addr = 6'd7;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    check("t6_first_if_gnt", 32'(if_gnt), 32'd1);
    edge_in();
    if_req = 1'b0;
    @(negedge clk);
    check("t6_dm_gnt", 32'(dm_gnt), 32'd1);
    check("t6_old_rdata", if_rdata, 32'h0);
    edge_in();
    dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1;
    @(negedge clk);
    check("t6_if_gnt", 32'(if_gnt), 32'd1);
`else
    check("t6_first_dm_gnt", 32'(dm_gnt), 32'd1);
    check("t6_first_if_gnt", 32'(if_gnt), 32'd0);
    edge_in();
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check("t6_if_gnt", 32'(if_gnt), 32'd1);
    check("t6_no_dm_rvalid", 32'(dm_rvalid), 32'd0);
`endif
    edge_in();
    if_req = 1'b0;
    @(negedge clk);
    check("t6_if_rvalid", 32'(if_rvalid), 32'd1);
    check("t6_new_rdata", if_rdata, 32'hA5A5A5A5);

    edge_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
